// File: rtl/chebyii_pkg.sv
// Shared constants, coefficient index helpers and commit FSM states for the
// Chebyshev-II biquad coefficient loader.
package chebyii_pkg;

  localparam int COEF_W = 16;
  localparam int N_SOS  = 3;
  localparam int N_COEF = 5 * N_SOS;

  localparam int K_B0 = 0;
  localparam int K_B1 = 1;
  localparam int K_B2 = 2;
  localparam int K_A1 = 3;
  localparam int K_A2 = 4;

  localparam logic [3:0] ADDR_RSVD = 4'd15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    COPY    = 2'd2
  } state_t;

  function automatic logic [3:0] coef_idx(input int sos, input int k);
    return 4'(5 * sos + k);
  endfunction

endpackage

// File: rtl/chebyii_coef_bank.sv
// Shadow coefficient array: single write port, registered readback and a
// flat parallel view used by the active-bank load.
module chebyii_coef_bank #(
  parameter int           W        = 16,
  parameter logic [W-1:0] RESET_B0 = 16'h4000
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_we,
  input  logic [3:0]                         i_waddr,
  input  logic [W-1:0]                       i_wdata,
  input  logic [3:0]                         i_raddr,
  output logic [W-1:0]                       o_rd_data,
  output logic [chebyii_pkg::N_COEF*W-1:0]   o_shadow
);
  import chebyii_pkg::*;

  logic [W-1:0] r_mem [N_COEF];
  logic [W-1:0] r_rd_data;

  // Readback samples the pre-write value when reading the entry being written.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N_COEF; i++)
        r_mem[i] <= ((i % 5) == K_B0) ? RESET_B0 : '0;
      r_rd_data <= '0;
    end else begin
      if (i_we && (i_waddr < 4'(N_COEF)))
        r_mem[i_waddr] <= i_wdata;
      r_rd_data <= (i_raddr < 4'(N_COEF)) ? r_mem[i_raddr] : '0;
    end
  end

  assign o_rd_data = r_rd_data;

  for (genvar g = 0; g < N_COEF; g++) begin : g_flat
    assign o_shadow[g*W +: W] = r_mem[g];
  end

endmodule

// File: rtl/chebyii_coef_loader.sv
// Coefficient loader: shadow bank writes, sample-aligned commit into the
// active bank that feeds the biquad cascade.
module chebyii_coef_loader #(
  parameter int                COEF_W   = chebyii_pkg::COEF_W,
  parameter logic [COEF_W-1:0] RESET_B0 = 16'h4000
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst_n,
  input  logic                                   i_wr_valid,
  output logic                                   o_wr_ready,
  input  logic [3:0]                             i_wr_addr,
  input  logic [COEF_W-1:0]                      i_wr_data,
  input  logic                                   i_commit,
  input  logic                                   i_sample_tick,
  input  logic [3:0]                             i_rd_addr,
  output logic [COEF_W-1:0]                      o_rd_data,
  output logic                                   o_busy,
  output logic                                   o_done,
  output logic                                   o_err,
  output logic [chebyii_pkg::N_COEF*COEF_W-1:0]  o_coef
);
  import chebyii_pkg::*;

  state_t                    r_state, w_next;
  logic                      r_wr_ready, r_busy, r_done, r_err;
  logic [COEF_W-1:0]         r_active [N_COEF];
  logic [N_COEF*COEF_W-1:0]  w_shadow;
  logic                      w_accept;

  assign w_accept = i_wr_valid & r_wr_ready;

  chebyii_coef_bank #(.W(COEF_W), .RESET_B0(RESET_B0)) u_bank (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_we      (w_accept),
    .i_waddr   (i_wr_addr),
    .i_wdata   (i_wr_data),
    .i_raddr   (i_rd_addr),
    .o_rd_data (o_rd_data),
    .o_shadow  (w_shadow)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_commit)      w_next = PENDING;
      PENDING: if (i_sample_tick) w_next = COPY;
      COPY:                       w_next = IDLE;
      default:                    w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Handshake/status flags are registered from the next state so they line up
  // with the state they describe without any input-to-output path.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ready <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      for (int i = 0; i < N_COEF; i++)
        r_active[i] <= ((i % 5) == K_B0) ? RESET_B0 : '0;
    end else begin
      r_wr_ready <= (w_next == IDLE);
      r_busy     <= (w_next != IDLE);
      r_done     <= (r_state == COPY);
      r_err      <= r_err | (w_accept & (i_wr_addr == ADDR_RSVD));
      if (r_state == COPY)
        for (int i = 0; i < N_COEF; i++)
          r_active[i] <= w_shadow[i*COEF_W +: COEF_W];
    end
  end

  assign o_wr_ready = r_wr_ready;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_err      = r_err;

  for (genvar g = 0; g < N_COEF; g++) begin : g_coef
    assign o_coef[g*COEF_W +: COEF_W] = r_active[g];
  end

endmodule

// File: tb/tb_chebyii_coef_loader.sv
// Directed and randomized checks of the coefficient loader against a
// bookkeeping model of the shadow/active banks and commit window.
module tb_chebyii_coef_loader;
  localparam int W = 16;
  localparam int N = 15;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           wr_valid, wr_ready, commit, tick, busy, done, err;
  logic [3:0]     wr_addr, rd_addr;
  logic [W-1:0]   wr_data, rd_data;
  logic [N*W-1:0] coef;

  chebyii_coef_loader #(.COEF_W(W), .RESET_B0(16'h4000)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_commit(commit),
    .i_sample_tick(tick), .i_rd_addr(rd_addr), .o_rd_data(rd_data),
    .o_busy(busy), .o_done(done), .o_err(err), .o_coef(coef)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: win 0 = no commit outstanding, 1 = waiting for a tick, 2 = load cycle.
  logic [W-1:0] sh [N];
  logic [W-1:0] act [N];
  logic [W-1:0] rd_m;
  logic         err_m, done_m, last_acc;
  int           win;

  function automatic logic [N*W-1:0] flat_act();
    logic [N*W-1:0] f;
    for (int i = 0; i < N; i++) f[i*W +: W] = act[i];
    return f;
  endfunction

  task automatic chk(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      sh[i]  = ((i % 5) == 0) ? 16'h4000 : 16'h0000;
      act[i] = sh[i];
    end
    rd_m = '0; err_m = 1'b0; done_m = 1'b0; win = 0;
  endtask

  task automatic check_all(input string ph);
    chk({ph, "_ready"}, N*W'(wr_ready), N*W'(win == 0));
    chk({ph, "_busy"},  N*W'(busy),     N*W'(win != 0));
    chk({ph, "_done"},  N*W'(done),     N*W'(done_m));
    chk({ph, "_err"},   N*W'(err),      N*W'(err_m));
    chk({ph, "_rd"},    N*W'(rd_data),  N*W'(rd_m));
    chk({ph, "_coef"},  coef,           flat_act());
  endtask

  task automatic step(input logic v, input logic [3:0] a, input logic [W-1:0] d,
                      input logic c, input logic tk, input logic [3:0] ra, input string ph);
    int nw;
    wr_valid = v; wr_addr = a; wr_data = d; commit = c; tick = tk; rd_addr = ra;
    last_acc = v && (win == 0);
    rd_m   = (ra < 4'd15) ? sh[ra] : '0;
    done_m = (win == 2);
    if (win == 2) for (int i = 0; i < N; i++) act[i] = sh[i];
    nw = (win == 0) ? (c ? 1 : 0) : (win == 1) ? (tk ? 2 : 1) : 0;
    if (last_acc) begin
      if (a < 4'd15) sh[a] = d;
      else           err_m = 1'b1;
    end
    win = nw;
    @(posedge clk);
    @(negedge clk);
    check_all(ph);
  endtask

  task automatic idle(input int n, input logic [3:0] ra, input string ph);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, '0, 1'b0, 1'b0, ra, ph);
  endtask

  // Reset asserted mid-cycle; outputs must fall back before any clock edge.
  task automatic do_reset(input string ph);
    wr_valid = 0; commit = 0; tick = 0;
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all({ph, "_async"});
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_all({ph, "_rel"});
  endtask

  initial begin
    rst_n = 1'b0; wr_valid = 0; wr_addr = 0; wr_data = 0; commit = 0; tick = 0; rd_addr = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_all("reset");
    chk("reset_b0_s0", N*W'(coef[0*W +: W]),  N*W'(16'h4000));
    chk("reset_b0_s1", N*W'(coef[5*W +: W]),  N*W'(16'h4000));
    chk("reset_b0_s2", N*W'(coef[10*W +: W]), N*W'(16'h4000));
    chk("reset_a1_s1", N*W'(coef[8*W +: W]),  N*W'(0));

    // Shadow write and readback; active bank untouched.
    step(1'b1, 4'd7, 16'h1234, 1'b0, 1'b0, 4'd7, "wr7");
    chk("wr7_old_rd", N*W'(rd_data), N*W'(0));
    idle(1, 4'd7, "rd7");
    chk("rd7_new", N*W'(rd_data), N*W'(16'h1234));
    chk("rd7_coef_unch", N*W'(coef[7*W +: W]), N*W'(0));

    // Commit at t, tick at t+5: load and DONE at t+7.
    step(1'b0, 4'd0, '0, 1'b1, 1'b0, 4'd7, "cm_t");
    chk("cm_ready_t1", N*W'(wr_ready), N*W'(0));
    idle(4, 4'd7, "cm_wait");
    step(1'b0, 4'd0, '0, 1'b0, 1'b1, 4'd7, "cm_tick");
    chk("cm_ready_t6", N*W'(wr_ready), N*W'(0));
    chk("cm_coef_t6", N*W'(coef[7*W +: W]), N*W'(0));
    idle(1, 4'd7, "cm_copy");
    chk("cm_done_t7", N*W'(done), N*W'(1));
    chk("cm_busy_t7", N*W'(busy), N*W'(0));
    chk("cm_coef_t7", N*W'(coef[7*W +: W]), N*W'(16'h1234));
    idle(1, 4'd0, "cm_after");
    chk("cm_done_t8", N*W'(done), N*W'(0));

    // Tick coincident with commit must not count.
    step(1'b1, 4'd3, 16'h0ABC, 1'b1, 1'b1, 4'd3, "ct_t");
    idle(2, 4'd3, "ct_wait");
    step(1'b0, 4'd0, '0, 1'b0, 1'b1, 4'd3, "ct_tick2");
    chk("ct_no_early", N*W'(coef[3*W +: W]), N*W'(0));
    idle(1, 4'd3, "ct_copy");
    chk("ct_done", N*W'(done), N*W'(1));
    chk("ct_coef3", N*W'(coef[3*W +: W]), N*W'(16'h0ABC));

    // Held write during PENDING lands in the shadow only after IDLE.
    step(1'b0, 4'd0, '0, 1'b1, 1'b0, 4'd2, "hw_cm");
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 4'd2, 16'h7FFF, 1'b0, (k == 1), 4'd2, "hw_hold");
      if (last_acc) break;
    end
    chk("hw_accepted", N*W'(last_acc), N*W'(1));
    idle(1, 4'd2, "hw_rd");
    chk("hw_rd2", N*W'(rd_data), N*W'(16'h7FFF));
    chk("hw_coef2", N*W'(coef[2*W +: W]), N*W'(0));

    // Reserved address, then reset in the middle of a pending commit.
    step(1'b1, 4'd15, 16'hBEEF, 1'b0, 1'b0, 4'd15, "rsvd");
    chk("rsvd_err", N*W'(err), N*W'(1));
    idle(2, 4'd15, "rsvd_hold");
    chk("rsvd_err_sticky", N*W'(err), N*W'(1));
    step(1'b0, 4'd0, '0, 1'b1, 1'b0, 4'd2, "rp_cm");
    idle(1, 4'd2, "rp_pend");
    do_reset("rp");
    chk("rp_err", N*W'(err), N*W'(0));
    chk("rp_coef3", N*W'(coef[3*W +: W]), N*W'(0));
    step(1'b0, 4'd0, '0, 1'b0, 1'b1, 4'd2, "rp_tick");
    idle(2, 4'd2, "rp_idle");
    chk("rp_no_done", N*W'(done), N*W'(0));
    chk("rp_shadow2", N*W'(rd_data), N*W'(0));

    // Randomized traffic with one mid-run reset.
    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset("rnd_rst");
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom()),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
           4'($urandom_range(0, 15)), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/chebyii_coef_loader.md
# chebyii_coef_loader

Coefficient register bank and commit controller that drives the 15 biquad coefficients of the 6th-order Chebyshev-II cascade. Software or a host sequencer writes coefficients one at a time into a shadow bank over a valid/ready port. A commit request copies the whole shadow bank into the active bank on a filter sample boundary, so the cascade never runs with a half-updated coefficient set. It sits between the control interface and the filter's coefficient inputs.

## Interface
- COEF_W, 16, coefficient width (signed, same format the biquads consume)
- RESET_B0, 16'h4000, reset value of every b_0 (unity gain); all other coefficients reset to 0
- CLK  in  1  system clock, all logic rising-edge
- RST  in  1  reset, asynchronous, active-low
- WR_VALID  in  1  write request
- WR_READY  out  1  write accepted when WR_VALID & WR_READY on a rising edge
- WR_ADDR  in  4  coefficient index, 0..14 valid
- WR_DATA  in  COEF_W  coefficient value
- COMMIT  in  1  single-cycle commit request
- SAMPLE_TICK  in  1  single-cycle strobe marking a filter sample boundary
- RD_ADDR  in  4  shadow readback index
- RD_DATA  out  COEF_W  shadow readback data, registered
- BUSY  out  1  commit in progress
- DONE  out  1  one-cycle pulse, first cycle new active coefficients are visible
- ERR  out  1  sticky: write to reserved address 15
- COEF  out  15*COEF_W  active coefficients, index i at bits [i*COEF_W +: COEF_W]

## Operation
- Address map: index = 5*sos + k, sos in 0..2, k = 0 b_0, 1 b_1, 2 b_2, 3 a_1, 4 a_2.
- Reset: both banks load the defaults (b_0 = RESET_B0, others 0). FSM goes to IDLE. WR_READY=1, BUSY=0, DONE=0, ERR=0, RD_DATA=0.
- FSM states:
  - IDLE: WR_READY=1. COMMIT moves to PENDING.
  - PENDING: WR_READY=0, BUSY=1. COMMIT is ignored. SAMPLE_TICK moves to COPY.
  - COPY: WR_READY=0, BUSY=1. Shadow is copied to active at the end of the cycle. Next state is IDLE.
- Accepted write to index 0..14 updates the shadow entry only. COEF does not change until a commit.
- A write to index 15 is consumed (handshake completes) and changes no register. It sets ERR, which stays set until reset.
- COMMIT and an accepted write in the same IDLE cycle: both take effect, and the committed set includes that write.
- A SAMPLE_TICK in the same cycle as COMMIT does not advance PENDING. Only a tick on a later cycle counts.
- RD_DATA = shadow[RD_ADDR], registered. Index 15 reads 0. A read of the entry being written in the same cycle returns the old value.
- Reset asserted at any point discards any pending commit, restores the defaults and suppresses DONE.

## Timing
- Write: shadow is updated at the handshake edge. Readback of that entry shows the new value 1 cycle later.
- Commit latency:
  - COMMIT in cycle t gives PENDING from t+1.
  - The first SAMPLE_TICK in cycle s ≥ t+1 gives COPY in s+1.
  - COEF shows the new values and DONE=1 in s+2. BUSY drops in s+2.
- WR_READY is low from t+1 through s+1 inclusive. Held writes complete in s+2 or later and land only in the shadow.
- COEF changes only at the COPY edge. All 15 entries update on the same edge.
- All outputs are registered. There are no combinational paths from input to output.

## Structure
- Package chebyii_pkg holds:
  - COEF_W, N_SOS=3, N_COEF=15
  - index constants for b_0..a_2 and the index = 5*sos + k helper
  - the FSM state enum (IDLE, PENDING, COPY)
- One sub-module is natural: chebyii_coef_bank, the 15-entry shadow array with a write port, registered readback and a parallel-load output. chebyii_coef_loader instantiates it and holds the FSM, the active bank and ERR/DONE.

## Test plan
- Reset with RST low, then release -> COEF index 0/5/10 = 16'h4000, all others 0; WR_READY=1, BUSY=0, DONE=0, ERR=0.
- Write index 7 = 16'h1234, then RD_ADDR=7 -> RD_DATA=16'h1234 one cycle later; COEF index 7 still 0.
- COMMIT at t, SAMPLE_TICK at t+5 -> COEF index 7 = 16'h1234 and DONE pulse exactly at t+7; WR_READY low t+1..t+6; BUSY low at t+7.
- COMMIT and SAMPLE_TICK in the same cycle, next tick 3 cycles later -> no load on the first tick; load and DONE 2 cycles after the second tick.
- Write during PENDING (index 2 = 16'h7FFF held valid) -> not accepted until IDLE; lands in the shadow only; COEF index 2 unchanged until the next commit.
- Write index 15 = 16'hBEEF -> handshake completes, ERR=1 and stays set, no register changes. RST low during PENDING -> defaults restored, ERR=0, no DONE.
